// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared states, constants and helpers for apb_regfile_slave (optional APB_PSTRB_EN lives in the top)
package apb_regfile_pkg;

  // Transfer sequencing: setup seen -> optional wait -> one-cycle response
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_t;

  localparam int APB_BYTE_W = 8;

  // Wide enough for the largest supported wait-state count (15)
  localparam int WAIT_CNT_W = 4;

  // Number of low address bits that select a byte inside one data word
  function automatic int byte_off_bits(input int data_w);
    return $clog2(data_w / APB_BYTE_W);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational PADDR to register index and valid flag
module apb_addr_decode #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] i_paddr,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_index
);
  import apb_regfile_pkg::*;

  localparam int                OFF_BITS = byte_off_bits(DATA_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_BITS) - 64'd1);

  // One extra bit so an address below BASE_ADDR shows up as a borrow
  logic [ADDR_W:0]   w_diff;
  logic [ADDR_W-1:0] w_word;

  assign w_diff  = {1'b0, i_paddr} - {1'b0, BASE_ADDR};
  assign w_word  = w_diff[ADDR_W-1:0] >> OFF_BITS;

  // BASE_ADDR is word aligned, so checking the offset bits of the difference
  // is the same as checking them on PADDR itself
  assign o_valid = !w_diff[ADDR_W]
                && ((w_diff[ADDR_W-1:0] & OFF_MASK) == '0)
                && (w_word < ADDR_W'(NUM_REGS));
  assign o_index = w_word[IDX_W-1:0];

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB4 register file completer; APB_PSTRB_EN enables byte-lane writes
module apb_regfile_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic                       PWRITE,
  input  logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W/8-1:0]        PSTRB,
  input  logic                       PSELx,
  input  logic                       PENABLE,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] o_regs
);
  import apb_regfile_pkg::*;

  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NUM_BYTES = DATA_W / APB_BYTE_W;

  apb_state_t            r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [IDX_W-1:0]      r_index, w_index_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic [DATA_W-1:0]     r_prdata, w_prdata_nxt;
  logic                  w_commit;

  logic                  w_dec_valid;
  logic [IDX_W-1:0]      w_dec_index;
  logic [IDX_W-1:0]      w_rd_index;
  logic [DATA_W-1:0]     w_rd_data;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  apb_addr_decode #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .i_paddr (PADDR),
    .o_valid (w_dec_valid),
    .o_index (w_dec_index)
  );

  // Read source: live decode on a zero-wait setup, latched index after waiting
  always_comb begin
    w_rd_index = (r_state == IDLE) ? w_dec_index : r_index;
    w_rd_data  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_index == IDX_W'(k)) begin
        w_rd_data = r_regs[k];
      end
    end
  end

  // Next state, latched decode and the response to register on entry to READY
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_valid_nxt   = r_valid;
    w_index_nxt   = r_index;
    w_write_nxt   = r_write;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    w_commit      = 1'b0;

    case (r_state)
      IDLE: begin
        if (PSELx && !PENABLE) begin
          w_valid_nxt = w_dec_valid;
          w_index_nxt = w_dec_index;
          w_write_nxt = PWRITE;
          if (WAIT_STATES == 0) begin
            w_state_nxt   = READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = !w_dec_valid;
            w_prdata_nxt  = (w_dec_valid && !PWRITE) ? w_rd_data : '0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end

      WAIT: begin
        if (!PSELx) begin
          // Requester gave up: drop the transfer without a response
          w_state_nxt = IDLE;
        end else if (PENABLE) begin
          if (r_cnt == WAIT_CNT_W'(1)) begin
            w_state_nxt   = READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = !r_valid;
            w_prdata_nxt  = (r_valid && !r_write) ? w_rd_data : '0;
          end else begin
            w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
          end
        end
      end

      READY: begin
        w_state_nxt = IDLE;
        w_commit    = PSELx && PENABLE && r_write && r_valid;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched decode and the registered APB response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_index   <= '0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_index   <= w_index_nxt;
      r_write   <= w_write_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
    end
  end

  // Register file; a write lands on the edge that closes the READY cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_index == IDX_W'(k)) begin
`ifdef APB_PSTRB_EN
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (PSTRB[b]) begin
              r_regs[k][b*APB_BYTE_W +: APB_BYTE_W] <= PWDATA[b*APB_BYTE_W +: APB_BYTE_W];
            end
          end
`else
          r_regs[k] <= PWDATA;
`endif
        end
      end
    end
  end

`ifndef APB_PSTRB_EN
  // Strobes only matter when byte-lane writes are built in
  logic w_unused_pstrb;
  assign w_unused_pstrb = ^PSTRB;
`endif

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - scoreboard bench for apb_regfile_slave, zero-wait and three-wait instances
`timescale 1ns/1ps
module tb_apb_regfile_slave;

  localparam int          NR    = 8;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_0100;

  logic         clk;
  logic         rst;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         psel0, psel3, penable;
  logic [31:0]  prdata0, prdata3;
  logic         pready0, pready3, pslverr0, pslverr3;
  logic [255:0] regs0, regs3;

  int total = 0;
  int bad   = 0;

  logic [31:0] model0 [NR];
  logic [31:0] model3 [NR];

  typedef struct {
    bit          d3;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(NR), .BASE_ADDR(BASE0), .WAIT_STATES(0)
  ) u_dut0 (
    .i_clk(clk), .i_reset(rst), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PSTRB(pstrb), .PSELx(psel0), .PENABLE(penable), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .o_regs(regs0)
  );

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(NR), .BASE_ADDR(BASE3), .WAIT_STATES(3)
  ) u_dut3 (
    .i_clk(clk), .i_reset(rst), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PSTRB(pstrb), .PSELx(psel3), .PENABLE(penable), .PRDATA(prdata3),
    .PREADY(pready3), .PSLVERR(pslverr3), .o_regs(regs3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit decode(input logic [31:0] addr, input logic [31:0] base, output int idx);
    logic [31:0] off;
    idx = 0;
    if (addr < base) return 1'b0;
    if (addr[1:0] != 2'b00) return 1'b0;
    off = (addr - base) >> 2;
    if (off >= NR) return 1'b0;
    idx = int'(off);
    return 1'b1;
  endfunction

`ifdef APB_PSTRB_EN
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    end
    return r;
  endfunction
`endif

  function automatic logic [31:0] word_of(input bit d3, input int k);
    return d3 ? regs3[k*32 +: 32] : regs0[k*32 +: 32];
  endfunction

  function automatic logic [31:0] model_of(input bit d3, input int k);
    return d3 ? model3[k] : model0[k];
  endfunction

  task automatic regs_check(input bit d3, input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_d%0d_r%0d", tag, d3 ? 3 : 0, k), word_of(d3, k), model_of(d3, k));
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NR; k++) begin
      model0[k] = '0;
      model3[k] = '0;
    end
  endtask

  // Called #1 after a rising edge; this cycle becomes the setup phase
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t        e;
    int          idx;
    bit          ok;
    int          n;
    logic [31:0] old;
    logic [31:0] nw;
    ok     = decode(addr, d3 ? BASE3 : BASE0, idx);
    old    = ok ? model_of(d3, idx) : 32'h0;
    e.d3   = d3;
    e.err  = !ok;
    e.data = (ok && !wr) ? old : 32'h0;
    sb.push_back(e);
`ifdef APB_PSTRB_EN
    nw = merge(old, data, strb);
`else
    nw = data;
`endif
    if (ok && wr) begin
      if (d3) model3[idx] = nw;
      else    model0[idx] = nw;
    end

    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    pstrb   = strb;
    psel0   = !d3;
    psel3   = d3;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    while (!(d3 ? pready3 : pready0) && n < 40) begin
      chk("wait_prdata", d3 ? prdata3 : prdata0, 32'h0);
      if (ok && wr) chk("early_write", word_of(d3, idx), old);
      @(posedge clk); #1;
      n++;
    end
    if (!(d3 ? pready3 : pready0)) begin
      chk("pready_timeout", 32'h0, 32'h1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("prdata", d3 ? prdata3 : prdata0, e.data);
      chk("pslverr", 32'(d3 ? pslverr3 : pslverr0), 32'(e.err));
      chk("latency", 32'(n), d3 ? 32'd4 : 32'd1);
    end
    @(posedge clk); #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    chk("pready_drop", 32'(d3 ? pready3 : pready0), 32'h0);
    chk("prdata_idle", d3 ? prdata3 : prdata0, 32'h0);
    if (ok && wr) chk("o_regs_word", word_of(d3, idx), model_of(d3, idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_pready0", 32'(pready0), 32'h0);
    chk("rst_pslverr0", 32'(pslverr0), 32'h0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pready3", 32'(pready3), 32'h0);
    regs_check(1'b0, "rst");
    regs_check(1'b1, "rst");

    // zero-wait read of reg 3 straight after reset
    xfer(1'b0, 1'b0, 32'h0C, 32'h0, 4'hF);

    // write then read back reg 5
    xfer(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 1'b0, 32'h14, 32'h0, 4'hF);
    chk("reg5_const", regs0[5*32 +: 32], 32'hDEADBEEF);

    // fill all registers, read back in reverse order
    for (int k = 0; k < NR; k++) xfer(1'b0, 1'b1, 32'(k * 4), $urandom, 4'hF);
    for (int k = NR - 1; k >= 0; k--) xfer(1'b0, 1'b0, 32'(k * 4), 32'h0, 4'hF);

    // out-of-range and misaligned accesses
    xfer(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, 1'b1, 32'h06, 32'h1234_5678, 4'hF);
    xfer(1'b0, 1'b0, 32'h07, 32'h0, 4'hF);
    xfer(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
    regs_check(1'b0, "err_keep");

    // three wait states, non-zero base
    xfer(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    xfer(1'b1, 1'b1, 32'h11C, 32'hCAFE_F00D, 4'hF);
    xfer(1'b1, 1'b0, 32'h11C, 32'h0, 4'hF);
    xfer(1'b1, 1'b0, 32'h0FC, 32'h0, 4'hF);
    xfer(1'b1, 1'b1, 32'h120, 32'h5A5A_5A5A, 4'hF);
    xfer(1'b1, 1'b1, 32'h102, 32'h5A5A_5A5A, 4'hF);
    regs_check(1'b1, "ws_keep");

    // byte strobes on reg 2
    xfer(1'b0, 1'b1, 32'h08, 32'h1122_3344, 4'hF);
    xfer(1'b0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101);
    xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'hF);
`ifdef APB_PSTRB_EN
    chk("pstrb_merge", regs0[2*32 +: 32], 32'h11BB_33DD);
    xfer(1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
    chk("pstrb_none", regs0[2*32 +: 32], 32'h11BB_33DD);
`else
    chk("pstrb_ignored", regs0[2*32 +: 32], 32'hAABB_CCDD);
`endif

    // select dropped in the middle of the wait
    xfer(1'b1, 1'b1, 32'h108, 32'h5555_AAAA, 4'hF);
    paddr = 32'h108; pwrite = 1'b1; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    repeat (6) begin
      chk("abort_pready", 32'(pready3), 32'h0);
      @(posedge clk); #1;
    end
    chk("abort_reg2", regs3[2*32 +: 32], model3[2]);
    xfer(1'b1, 1'b0, 32'h108, 32'h0, 4'hF);

    // reset during the wait of a write to reg 1
    xfer(1'b1, 1'b1, 32'h104, 32'h7777_1111, 4'hF);
    paddr = 32'h104; pwrite = 1'b1; pwdata = 32'h9999_8888; pstrb = 4'hF;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    chk("rstmid_pready", 32'(pready3), 32'h0);
    chk("rstmid_reg1", regs3[1*32 +: 32], 32'h0);
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    regs_check(1'b1, "rstmid");
    regs_check(1'b0, "rstmid");
    xfer(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
    xfer(1'b0, 1'b0, 32'h14, 32'h0, 4'hF);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
